// File: rtl/bidi_bus_arbiter.sv
// Two-sided owner arbiter for a shared bidirectional link: mutually exclusive drive enables
// with guaranteed turnaround dead cycles. Define BIDI_BURST_LIMIT_EN to cap ownership at MAX_BURST.
module bidi_bus_arbiter #(
   parameter int unsigned TURN_CYCLES = 2,
   parameter int unsigned MAX_BURST   = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_a,
   input  logic req_b,
   input  logic done_a,
   input  logic done_b,
   output logic gnt_a,
   output logic gnt_b,
   output logic a_drv_en,
   output logic b_drv_en,
   output logic turn_active,
   output logic burst_expired
);

   typedef enum logic [1:0] {StIdle, StOwnA, StOwnB, StTurn} state_e;

   localparam logic [3:0] TurnLoad = 4'(TURN_CYCLES - 1);
   localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

   state_e     state_q;
   logic       last_b_q;
   logic [3:0] turn_cnt_q;
   logic       gnt_a_q;
   logic       gnt_b_q;
   logic       turn_q;
   logic       expired_q;
   logic       burst_hit;
   logic       pick_a;

`ifdef BIDI_BURST_LIMIT_EN
   logic [7:0] burst_cnt_q;
   logic [7:0] burst_inc;

   assign burst_inc = (burst_cnt_q < MaxBurst) ? burst_cnt_q + 8'd1 : burst_cnt_q;
   assign burst_hit = (burst_inc >= MaxBurst);

   // Counter is held at zero outside ownership, so it is already clear on entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         burst_cnt_q <= 8'd0;
      end else if (state_q == StOwnA || state_q == StOwnB) begin
         burst_cnt_q <= burst_inc;
      end else begin
         burst_cnt_q <= 8'd0;
      end
   end
`else
   logic unused_max_burst;

   assign burst_hit        = 1'b0;
   assign unused_max_burst = ^MaxBurst;
`endif

   // Round-robin tie break: A wins unless A owned last.
   assign pick_a = req_a && (!req_b || last_b_q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         last_b_q   <= 1'b1;
         turn_cnt_q <= 4'd0;
         gnt_a_q    <= 1'b0;
         gnt_b_q    <= 1'b0;
         turn_q     <= 1'b0;
         expired_q  <= 1'b0;
      end else begin
         expired_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pick_a) begin
                  state_q <= StOwnA;
                  gnt_a_q <= 1'b1;
               end else if (req_b) begin
                  state_q <= StOwnB;
                  gnt_b_q <= 1'b1;
               end
            end
            StOwnA: begin
               if (done_a || !req_a || burst_hit) begin
                  state_q    <= StTurn;
                  turn_cnt_q <= TurnLoad;
                  last_b_q   <= 1'b0;
                  gnt_a_q    <= 1'b0;
                  turn_q     <= 1'b1;
                  expired_q  <= burst_hit && req_a && !done_a;
               end
            end
            StOwnB: begin
               if (done_b || !req_b || burst_hit) begin
                  state_q    <= StTurn;
                  turn_cnt_q <= TurnLoad;
                  last_b_q   <= 1'b1;
                  gnt_b_q    <= 1'b0;
                  turn_q     <= 1'b1;
                  expired_q  <= burst_hit && req_b && !done_b;
               end
            end
            StTurn: begin
               if (turn_cnt_q == 4'd0) begin
                  state_q <= StIdle;
                  turn_q  <= 1'b0;
               end else begin
                  turn_cnt_q <= turn_cnt_q - 4'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign gnt_a         = gnt_a_q;
   assign gnt_b         = gnt_b_q;
   assign a_drv_en      = gnt_a_q;
   assign b_drv_en      = gnt_b_q;
   assign turn_active   = turn_q;
   assign burst_expired = expired_q;

endmodule

// File: tb/tb_bidi_bus_arbiter.sv
// Directed vector bench for bidi_bus_arbiter (TURN_CYCLES=2, MAX_BURST=4).
module tb_bidi_bus_arbiter;

   logic clk = 1'b0;
   logic rst_n, req_a, req_b, done_a, done_b;
   logic gnt_a, gnt_b, a_drv_en, b_drv_en, turn_active, burst_expired;
   int   tests = 0;
   int   fails = 0;
   logic running = 1'b1;

   always #5 clk = ~clk;

   bidi_bus_arbiter #(
      .TURN_CYCLES (2),
      .MAX_BURST   (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_a         (req_a),
      .req_b         (req_b),
      .done_a        (done_a),
      .done_b        (done_b),
      .gnt_a         (gnt_a),
      .gnt_b         (gnt_b),
      .a_drv_en      (a_drv_en),
      .b_drv_en      (b_drv_en),
      .turn_active   (turn_active),
      .burst_expired (burst_expired)
   );

   typedef struct {
      logic rst_n, req_a, req_b, done_a, done_b;
      logic ga, gb, ta, be;
   } vec_t;

   vec_t vecs[35];

   task automatic check(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Enables must never be on together.
   always @(negedge clk) begin
      if (running && rst_n === 1'b1) check("mutex_drv_en", a_drv_en & b_drv_en, 1'b0);
   end

   function automatic vec_t mk(input logic r, ra, rb, da, db, ga, gb, ta, be);
      vec_t v;
      v.rst_n = r; v.req_a = ra; v.req_b = rb; v.done_a = da; v.done_b = db;
      v.ga = ga; v.gb = gb; v.ta = ta; v.be = be;
      return v;
   endfunction

   initial begin
      rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1; done_a = 1'b0; done_b = 1'b0;
      // Reset with both requests, then A wins the first tie
      vecs[0]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0);
      vecs[2]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0);
      vecs[3]  = mk(1, 1, 1, 0, 0, 1, 0, 0, 0);
      // Round-robin with both requests held
      vecs[4]  = mk(1, 1, 1, 0, 0, 1, 0, 0, 0);
      vecs[5]  = mk(1, 1, 1, 1, 0, 0, 0, 1, 0);
      vecs[6]  = mk(1, 1, 1, 0, 0, 0, 0, 1, 0);
      vecs[7]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0);
      vecs[8]  = mk(1, 1, 1, 0, 0, 0, 1, 0, 0);
      vecs[9]  = mk(1, 1, 1, 0, 0, 0, 1, 0, 0);
      vecs[10] = mk(1, 1, 1, 0, 1, 0, 0, 1, 0);
      vecs[11] = mk(1, 1, 1, 0, 0, 0, 0, 1, 0);
      vecs[12] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0);
      vecs[13] = mk(1, 1, 1, 0, 0, 1, 0, 0, 0);
      // Foreign done and req_b toggles ignored, withdrawal releases
      vecs[14] = mk(1, 1, 0, 0, 1, 1, 0, 0, 0);
      vecs[15] = mk(1, 1, 1, 0, 0, 1, 0, 0, 0);
      vecs[16] = mk(1, 1, 0, 0, 1, 1, 0, 0, 0);
      vecs[17] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0);
      vecs[18] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0);
      vecs[19] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
      // Single owner B, done on 4th owned cycle (normal release even with burst limit)
      vecs[20] = mk(1, 0, 1, 0, 0, 0, 1, 0, 0);
      vecs[21] = mk(1, 0, 1, 1, 0, 0, 1, 0, 0);
      vecs[22] = mk(1, 0, 1, 0, 0, 0, 1, 0, 0);
      vecs[23] = mk(1, 0, 1, 0, 0, 0, 1, 0, 0);
      vecs[24] = mk(1, 0, 1, 0, 1, 0, 0, 1, 0);
      vecs[25] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0);
      vecs[26] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[27] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
      // Mid-operation reset during OWN_B: no turnaround, then A wins the tie
      vecs[28] = mk(1, 0, 1, 0, 0, 0, 1, 0, 0);
      vecs[29] = mk(1, 0, 1, 0, 0, 0, 1, 0, 0);
      vecs[30] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0);
      vecs[31] = mk(1, 1, 1, 0, 0, 1, 0, 0, 0);
      vecs[32] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0);
      vecs[33] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0);
      vecs[34] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 35; i++) begin
         rst_n  = vecs[i].rst_n;
         req_a  = vecs[i].req_a;
         req_b  = vecs[i].req_b;
         done_a = vecs[i].done_a;
         done_b = vecs[i].done_b;
         step();
         check($sformatf("v%0d gnt_a", i), gnt_a, vecs[i].ga);
         check($sformatf("v%0d gnt_b", i), gnt_b, vecs[i].gb);
         check($sformatf("v%0d a_drv_en", i), a_drv_en, vecs[i].ga);
         check($sformatf("v%0d b_drv_en", i), b_drv_en, vecs[i].gb);
         check($sformatf("v%0d turn_active", i), turn_active, vecs[i].ta);
         check($sformatf("v%0d burst_expired", i), burst_expired, vecs[i].be);
      end

      // Burst limit: A holds request with no done
      rst_n = 1'b1; req_a = 1'b1; req_b = 1'b0; done_a = 1'b0; done_b = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("burst own%0d gnt_a", k), gnt_a, 1'b1);
         check($sformatf("burst own%0d expired", k), burst_expired, 1'b0);
      end
`ifdef BIDI_BURST_LIMIT_EN
      step();
      check("burst release gnt_a", gnt_a, 1'b0);
      check("burst release turn", turn_active, 1'b1);
      check("burst release expired", burst_expired, 1'b1);
      req_b = 1'b1;
      step();
      check("burst turn2 expired", burst_expired, 1'b0);
      check("burst turn2 turn", turn_active, 1'b1);
      step();
      check("burst idle turn", turn_active, 1'b0);
      check("burst idle gnt_a", gnt_a, 1'b0);
      step();
      check("burst next gnt_b", gnt_b, 1'b1);
      check("burst next gnt_a", gnt_a, 1'b0);
`else
      req_b = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         check($sformatf("unbounded%0d gnt_a", k), gnt_a, 1'b1);
         check($sformatf("unbounded%0d gnt_b", k), gnt_b, 1'b0);
         check($sformatf("unbounded%0d expired", k), burst_expired, 1'b0);
      end
`endif
      running = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
